// File: rtl/iccm_access_arbiter.sv
// ICCM arbiter between the loader write buffer and core instruction fetches.
// Define ICCM_ARB_STARVE_GUARD_EN to let queued writes preempt a long-running core fetch stream.
module iccm_access_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_we_i,
  input  logic [13:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  input  logic        ld_reset_i,
  input  logic        core_req_i,
  input  logic [13:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        mem_csb_o,
  output logic        mem_web_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        core_rst_no,
  output logic        fifo_full_o,
  output logic        overflow_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, DRAIN, RUN} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             core_rst_q, core_rst_d;
  logic             rvalid_q, rvalid_d;
  logic [13:0]      fifo_addr_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];

  logic fifo_empty, push, pop, starve_fire;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full_o = (count_q == CNT_W'(FIFO_DEPTH));

  // Core wins only in RUN; every other cycle a non-empty FIFO drains one word.
  assign core_gnt_o = (state_q == RUN) && core_req_i && !starve_fire;
  assign pop        = !fifo_empty && !core_gnt_o;
  assign push       = ld_we_i && (!fifo_full_o || pop);

  assign mem_csb_o   = !(core_gnt_o || pop);
  assign mem_web_o   = !pop;
  assign mem_addr_o  = core_gnt_o ? core_addr_i : fifo_addr_q[rd_ptr_q];
  assign mem_wdata_o = fifo_data_q[rd_ptr_q];

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rvalid_q ? mem_rdata_i : 32'h0;
  assign core_rst_no   = core_rst_q;
  assign overflow_o    = overflow_q;

`ifdef ICCM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_q, starve_d;

  assign starve_fire = (starve_q == SC_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (core_gnt_o && !fifo_empty && !starve_fire) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  // Strict core priority; the limit only matters when the guard is built in.
  assign starve_fire = 1'b0 && (STARVE_LIMIT > 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    if (!ld_reset_i) state_d = DRAIN;
      DRAIN:   if (ld_reset_i) state_d = BOOT;
               else if (fifo_empty) state_d = RUN;
      RUN:     if (ld_reset_i) state_d = BOOT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q || (ld_we_i && fifo_full_o && !pop);
    // Core reset rises one cycle after RUN is entered, falls on the edge into BOOT.
    core_rst_d = (state_q == RUN) && (state_d == RUN);
    rvalid_d   = core_gnt_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      core_rst_q <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      core_rst_q <= core_rst_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ld_addr_i;
      fifo_data_q[wr_ptr_q] <= ld_wdata_i;
    end
  end

endmodule
